fun_unit: RTL and testbench

Registered 3-input Boolean function evaluator. Each cycle it maps inputs `a`, `b`, `c` through an 8-entry truth table, programmable at run time, to a single output bit `f`. It also tracks which input combinations (minterms) have been exercised and counts evaluations that produced 1. It sits in the logic-function lab datapath as a generic 3-to-1 combinational primitive with a clocked, observable output.

---
 rtl/fun_unit_if.sv | 39 +++
 rtl/fun_unit.sv | 100 ++++++++++
 tb/tb_fun_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fun_unit_if.sv
// fun_unit_if: evaluation, table-write and status signals of fun_unit.
// The coverage signals (cov_mask, cov_full, cov_clr) exist only when
// FUN_COVERAGE_EN is defined.
interface fun_unit_if #(
    parameter int CNT_W = 8
);
    logic             a;
    logic             b;
    logic             c;
    logic             in_valid;
    logic             tt_we;
    logic [7:0]       tt_data;
    logic             f;
    logic             f_valid;
    logic [CNT_W-1:0] ones_cnt;
`ifdef FUN_COVERAGE_EN
    logic [7:0]       cov_mask;
    logic             cov_full;
    logic             cov_clr;

    modport master (
        output a, b, c, in_valid, tt_we, tt_data, cov_clr,
        input  f, f_valid, ones_cnt, cov_mask, cov_full
    );
    modport slave (
        input  a, b, c, in_valid, tt_we, tt_data, cov_clr,
        output f, f_valid, ones_cnt, cov_mask, cov_full
    );
`else
    modport master (
        output a, b, c, in_valid, tt_we, tt_data,
        input  f, f_valid, ones_cnt
    );
    modport slave (
        input  a, b, c, in_valid, tt_we, tt_data,
        output f, f_valid, ones_cnt
    );
`endif
endinterface

// File: rtl/fun_unit.sv
// fun_unit: registered 3-input Boolean function evaluator with a run-time
// programmable 8-entry truth table (index {a,b,c}), a saturating count of
// evaluations that produced 1, and optional minterm coverage tracking
// enabled by defining FUN_COVERAGE_EN.
module fun_unit #(
    parameter logic [7:0] TT_RESET = 8'hB8,
    parameter int         CNT_W    = 8
) (
    input  logic      clk,
    input  logic      rst,
    fun_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [2:0]       idx_s;
    logic             r_s;
    logic [7:0]       tt_d,  tt_q;
    logic             f_d,   f_q;
    logic             f_valid_d, f_valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Look up the result from the current table and compute next state;
    // a table write lands next cycle, so this cycle's lookup sees the old table.
    always_comb begin
        idx_s     = {bus.a, bus.b, bus.c};
        r_s       = tt_q[idx_s];
        tt_d      = tt_q;
        f_d       = f_q;
        f_valid_d = 1'b0;
        cnt_d     = cnt_q;
        if (bus.tt_we) begin
            tt_d = bus.tt_data;
        end else begin
            tt_d = tt_q;
        end
        if (bus.in_valid) begin
            f_d       = r_s;
            f_valid_d = 1'b1;
            if (r_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            f_d       = f_q;
            f_valid_d = 1'b0;
        end
    end

    // State registers; reset restores the default table and clears results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q      <= TT_RESET;
            f_q       <= 1'b0;
            f_valid_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            tt_q      <= tt_d;
            f_q       <= f_d;
            f_valid_q <= f_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.f        = f_q;
    assign bus.f_valid  = f_valid_q;
    assign bus.ones_cnt = cnt_q;

`ifdef FUN_COVERAGE_EN
    logic [7:0] cov_mask_d, cov_mask_q;

    // Clear first, then mark the minterm evaluated this cycle.
    always_comb begin
        cov_mask_d = cov_mask_q;
        if (bus.cov_clr) begin
            cov_mask_d = 8'h00;
        end else begin
            cov_mask_d = cov_mask_q;
        end
        if (bus.in_valid) begin
            cov_mask_d[idx_s] = 1'b1;
        end else begin
            cov_mask_d[idx_s] = cov_mask_d[idx_s];
        end
    end

    // Coverage mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov_mask_q <= 8'h00;
        end else begin
            cov_mask_q <= cov_mask_d;
        end
    end

    assign bus.cov_mask = cov_mask_q;
    assign bus.cov_full = (cov_mask_q == 8'hFF);
`endif
endmodule

// File: tb/tb_fun_unit.sv
// tb_fun_unit: table-driven directed vectors plus randomized stimulus
// checked against a behavioural model of fun_unit.
module tb_fun_unit;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fun_unit_if #(.CNT_W(CNT_W)) bus();

    fun_unit #(.TT_RESET(8'hB8), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [7:0] tt_m;
    logic [7:0] cov_m;
    logic       f_m;
    logic       fv_m;
    int         cnt_m;
    logic       clr_v;

    typedef struct {
        logic [2:0] abc;
        logic       v;
        logic       we;
        logic [7:0] d;
        logic       exp_f;
        logic       exp_fv;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic [2:0] abc, logic v, logic we, logic [7:0] d,
                                logic ef, logic efv);
        vec_t t;
        t.abc = abc; t.v = v; t.we = we; t.d = d; t.exp_f = ef; t.exp_fv = efv;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [2:0] abc, logic v, logic we, logic [7:0] d, logic clr);
        bus.a       = abc[2];
        bus.b       = abc[1];
        bus.c       = abc[0];
        bus.in_valid = v;
        bus.tt_we   = we;
        bus.tt_data = d;
        clr_v       = clr;
`ifdef FUN_COVERAGE_EN
        bus.cov_clr = clr;
`endif
    endtask

    task automatic model_reset();
        tt_m  = 8'hB8;
        cov_m = 8'h00;
        f_m   = 1'b0;
        fv_m  = 1'b0;
        cnt_m = 0;
    endtask

    // One clock edge as the specification describes it, using the inputs
    // currently on the bus.
    task automatic model_edge();
        int idx;
        idx = 0;
        if (bus.in_valid === 1'b1) begin
            idx  = int'({bus.a, bus.b, bus.c});
            f_m  = tt_m[idx];
            fv_m = 1'b1;
            if (f_m) cnt_m = (cnt_m + 1 > CMAX) ? CMAX : cnt_m + 1;
        end else begin
            fv_m = 1'b0;
        end
        if (clr_v) cov_m = 8'h00;
        if (bus.in_valid === 1'b1) cov_m[idx] = 1'b1;
        if (bus.tt_we) tt_m = bus.tt_data;
    endtask

    task automatic compare_all(string tag);
        chk({tag, ".f"},        32'(bus.f),        32'(f_m));
        chk({tag, ".f_valid"},  32'(bus.f_valid),  32'(fv_m));
        chk({tag, ".ones_cnt"}, 32'(bus.ones_cnt), cnt_m);
`ifdef FUN_COVERAGE_EN
        chk({tag, ".cov_mask"}, 32'(bus.cov_mask), 32'(cov_m));
        chk({tag, ".cov_full"}, 32'(bus.cov_full), 32'(cov_m == 8'hFF));
`endif
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [7:0] b8;
        b8 = 8'hB8;
        rst = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 8'h00, 1'b0);
        model_reset();
        #1;
        compare_all("reset");
        chk("reset.f_const", 32'(bus.f), 32'd0);
        chk("reset.cnt_const", 32'(bus.ones_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // exhaustive default table, 100 twice more, reprogram, idle hold
        tbl[0]  = mk(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[1]  = mk(3'b001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[2]  = mk(3'b010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[3]  = mk(3'b011, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[4]  = mk(3'b100, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[5]  = mk(3'b101, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[6]  = mk(3'b110, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[7]  = mk(3'b111, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[8]  = mk(3'b100, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[9]  = mk(3'b100, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[10] = mk(3'b111, 1'b1, 1'b1, 8'h96, 1'b1, 1'b1);
        tbl[11] = mk(3'b111, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[12] = mk(3'b110, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[13] = mk(3'b111, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[14] = mk(3'bxxx, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[15] = mk(3'bxxx, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[16] = mk(3'bxxx, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].abc, tbl[i].v, tbl[i].we, tbl[i].d, 1'b0);
            step("tbl_model");
            chk($sformatf("tbl[%0d].f", i), 32'(bus.f), 32'(tbl[i].exp_f));
            chk($sformatf("tbl[%0d].f_valid", i), 32'(bus.f_valid), 32'(tbl[i].exp_fv));
            if (i == 9) begin
                chk("exhaustive.ones_cnt", 32'(bus.ones_cnt), 32'd6);
`ifdef FUN_COVERAGE_EN
                chk("exhaustive.cov_mask", 32'(bus.cov_mask), 32'hFF);
                chk("exhaustive.cov_full", 32'(bus.cov_full), 32'd1);
`endif
            end
        end
        chk("idle.ones_cnt", 32'(bus.ones_cnt), 32'd9);

`ifdef FUN_COVERAGE_EN
        drive(3'b010, 1'b1, 1'b0, 8'h00, 1'b1);
        step("covclr");
        chk("covclr.cov_mask", 32'(bus.cov_mask), 32'h04);
        chk("covclr.cov_full", 32'(bus.cov_full), 32'd0);
`endif

        // randomized stimulus against the model
        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 15) == 0));
            step("rand");
        end

        // saturation with an all-ones table
        drive(3'b000, 1'b0, 1'b1, 8'hFF, 1'b0);
        step("sat_wr");
        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(0, 7)), 1'b1, 1'b0, 8'h00, 1'b0);
            step("sat");
        end
        chk("sat.ones_cnt", 32'(bus.ones_cnt), 32'd255);
        chk("sat.f", 32'(bus.f), 32'd1);

        // asynchronous reset between edges
        drive(3'b101, 1'b1, 1'b1, 8'h00, 1'b0);
        step("arst_pre");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("arst");
        chk("arst.f_const", 32'(bus.f), 32'd0);
        chk("arst.f_valid_const", 32'(bus.f_valid), 32'd0);
        chk("arst.cnt_const", 32'(bus.ones_cnt), 32'd0);
`ifdef FUN_COVERAGE_EN
        chk("arst.cov_const", 32'(bus.cov_mask), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 1'b1, 1'b0, 8'h00, 1'b0);
            step("post_rst");
            chk($sformatf("post_rst.tt_b8[%0d]", i), 32'(bus.f), 32'(b8[i]));
            chk($sformatf("post_rst.f_valid[%0d]", i), 32'(bus.f_valid), 32'd1);
        end
        chk("post_rst.ones_cnt", 32'(bus.ones_cnt), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
